// File: rtl/rr_pkg.sv
// rr_pkg: shared state type and index helper for the lock-style round-robin arbiter.
package rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } rr_state_t;

  // Wrap-around increment: idx+1, or 0 once idx is the last of cnt positions.
  function automatic int next_idx(input int idx, input int cnt);
    if (idx >= cnt - 32'sd1) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker. Scans req starting at ptr,
// wrapping around, and reports the first requesting index.
module rr_pick
  import rr_pkg::*;
#(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = $clog2(REQCNT)
) (
  input  logic [REQCNT-1:0]   req_i,
  input  logic [REQWIDTH-1:0] ptr_i,
  output logic [REQWIDTH-1:0] idx_o,
  output logic                found_o
);

  logic [REQWIDTH-1:0] cand_s;

  // Walk all REQCNT positions from ptr; the first requesting position wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand_s  = ptr_i;
    for (int i = 0; i < REQCNT; i++) begin
      idx_o   = (!found_o && req_i[cand_s]) ? cand_s : idx_o;
      found_o = found_o | req_i[cand_s];
      cand_s  = REQWIDTH'(next_idx(32'(cand_s), REQCNT));
    end
  end

endmodule

// File: rtl/rr_lock_arb.sv
// rr_lock_arb: lock-style round-robin arbiter. A grantee keeps the resource
// until it releases, drops its request, or the hold watchdog fires; every
// grant is followed by one GAP cycle and one IDLE (arbitration) cycle.
module rr_lock_arb
  import rr_pkg::*;
#(
  parameter int REQCNT   = 5,
  parameter int REQWIDTH = $clog2(REQCNT),
  parameter int MAX_HOLD = 16,
  parameter int HOLDW    = $clog2(MAX_HOLD + 1)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [REQCNT-1:0]   req_i,
  input  logic [REQCNT-1:0]   rel_i,
  output logic [REQCNT-1:0]   gnt_o,
  output logic [REQWIDTH-1:0] gnt_num_o,
  output logic                gnt_val_o,
  output logic                timeout_o
);

  // A disabled watchdog gives HOLDW=0; keep the counter at least one bit wide.
  localparam int                CNTW     = (HOLDW < 1) ? 1 : HOLDW;
  localparam bit                WDOG_EN  = (MAX_HOLD != 0);
  localparam logic [CNTW-1:0]   HOLD_SAT = CNTW'(MAX_HOLD);
  localparam logic [CNTW-1:0]   HOLD_TC  = WDOG_EN ? CNTW'(MAX_HOLD - 1) : '0;
  localparam logic [REQCNT-1:0] ONE_HOT0 = {{(REQCNT-1){1'b0}}, 1'b1};

  rr_state_t           state_q, state_d;
  logic [REQWIDTH-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0]     hold_q, hold_d;
  logic [REQCNT-1:0]   gnt_q, gnt_d;
  logic [REQWIDTH-1:0] num_q, num_d;
  logic                val_q, val_d;
  logic                to_q, to_d;

  logic [REQWIDTH-1:0] pick_idx_s;
  logic                pick_found_s;
  logic [REQWIDTH-1:0] next_ptr_s;
  logic                release_s;

  rr_pick #(
    .REQCNT   (REQCNT),
    .REQWIDTH (REQWIDTH)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // The requester just served becomes lowest priority.
  assign next_ptr_s = REQWIDTH'(next_idx(32'(num_q), REQCNT));
  // Only the current grantee's release/request bits matter.
  assign release_s  = rel_i[num_q] || !req_i[num_q];

  // Next-state and output-register values for the IDLE -> GRANT -> GAP cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    num_d   = num_q;
    val_d   = val_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (pick_found_s) begin
          state_d = GRANT;
          gnt_d   = ONE_HOT0 << pick_idx_s;
          num_d   = pick_idx_s;
          val_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d = GAP;
          gnt_d   = '0;
          val_d   = 1'b0;
          ptr_d   = next_ptr_s;
        end else if (WDOG_EN && (hold_q == HOLD_TC)) begin
          state_d = GAP;
          gnt_d   = '0;
          val_d   = 1'b0;
          ptr_d   = next_ptr_s;
          to_d    = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + CNTW'(1'b1);
        end else begin
          hold_d = hold_q;
        end
      end
      GAP: begin
        state_d = IDLE;
        hold_d  = '0;
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
        gnt_d   = '0;
        val_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant at once and returns priority to 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      num_q   <= '0;
      val_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      num_q   <= num_d;
      val_q   <= val_d;
      to_q    <= to_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_num_o = num_q;
  assign gnt_val_o = val_q;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_rr_lock_arb.sv
// tb_rr_lock_arb: directed stimulus with a cycle-level behavioural model of the
// arbiter (owner / cycles held / priority pointer) checked on every falling edge,
// plus hand-computed literal expectations along the way.
module tb_rr_lock_arb;

  localparam int N        = 5;
  localparam int W        = $clog2(N);
  localparam int MAX_HOLD = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] rel   = '0;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_num;
  logic         gnt_val;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  rr_lock_arb #(
    .REQCNT   (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_i     (req),
    .rel_i     (rel),
    .gnt_o     (gnt),
    .gnt_num_o (gnt_num),
    .gnt_val_o (gnt_val),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  // Model: who owns the resource (-1 none), how long it has been visible,
  // the rotating priority start, whether the turnaround cycle is pending,
  // the last index granted, and whether this cycle shows a watchdog drop.
  typedef struct packed {
    int owner;
    int held;
    int ptr;
    bit gap;
    int last;
    bit to;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.owner = -1;
    r.held  = 0;
    r.ptr   = 0;
    r.gap   = 1'b0;
    r.last  = 0;
    r.to    = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic [N-1:0] rq,
                                        input logic [N-1:0] rl);
    model_t n;
    n    = cur;
    n.to = 1'b0;
    if (cur.owner >= 0) begin
      n.held = cur.held + 1;
      if (rl[cur.owner] || !rq[cur.owner]) begin
        n.owner = -1;
        n.gap   = 1'b1;
        n.ptr   = (cur.owner + 1) % N;
      end else if (MAX_HOLD != 0 && n.held == MAX_HOLD) begin
        n.owner = -1;
        n.gap   = 1'b1;
        n.ptr   = (cur.owner + 1) % N;
        n.to    = 1'b1;
      end
    end else if (cur.gap) begin
      n.gap = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (n.owner < 0 && rq[(cur.ptr + k) % N]) begin
          n.owner = (cur.ptr + k) % N;
          n.last  = n.owner;
          n.held  = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] exp_gnt(input model_t s);
    return (s.owner >= 0) ? (N'(1) << s.owner) : '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Advance the model on the same edges (and asynchronous reset) as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= model_reset();
    end else begin
      m <= model_next(m, req, rel);
    end
  end

  // Compare every output against the model, away from the rising edge.
  always @(negedge clk) begin
    check("cmp gnt_o", 32'(gnt), 32'(exp_gnt(m)));
    check("cmp gnt_val_o", 32'(gnt_val), 32'(m.owner >= 0));
    check("cmp gnt_num_o", 32'(gnt_num), 32'(m.last));
    check("cmp timeout_o", 32'(timeout), 32'(m.to));
  end

  localparam logic [3*N*2-1:0] ORDER_UNUSED = '0;

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 4, 0};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("rst gnt_o", 32'(gnt), 32'd0);
    check("rst gnt_val_o", 32'(gnt_val), 32'd0);
    check("rst gnt_num_o", 32'(gnt_num), 32'd0);
    check("rst timeout_o", 32'(timeout), 32'd0);

    // Single requester, released in its 4th grant cycle
    req = 5'b00100;
    step();
    check("t1 first grant", 32'(gnt), 32'h04);
    check("t1 first num", 32'(gnt_num), 32'd2);
    check("t1 first val", 32'(gnt_val), 32'd1);
    step(); step(); step();
    check("t1 4th grant cycle", 32'(gnt), 32'h04);
    rel = 5'b00100;
    step();
    rel = '0;
    check("t1 gap gnt", 32'(gnt), 32'd0);
    check("t1 gap timeout", 32'(timeout), 32'd0);
    check("t1 gap num held", 32'(gnt_num), 32'd2);
    step();
    check("t1 idle gnt", 32'(gnt), 32'd0);
    step();
    check("t1 regrant", 32'(gnt), 32'h04);
    req = '0;
    step(); step();
    // ptr must now be 3: {3,0} requesting picks 3
    req = 5'b01001;
    step();
    check("t1 ptr after release", 32'(gnt_num), 32'd3);
    req = '0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // All requesting, each grantee releases in its first cycle
    req = 5'b11111;
    step();
    for (int k = 0; k < 6; k++) begin
      check("t2 order gnt", 32'(gnt), 32'(N'(1) << order[k]));
      check("t2 order num", 32'(gnt_num), 32'(order[k]));
      rel = N'(1) << order[k];
      step();
      rel = '0;
      check("t2 gap", 32'(gnt_val), 32'd0);
      if (k == 5) begin
        req = '0;
      end
      step();
      check("t2 idle", 32'(gnt_val), 32'd0);
      step();
    end

    // Watchdog: hold without release for exactly MAX_HOLD cycles
    req = 5'b00010;
    step();
    for (int i = 0; i < MAX_HOLD; i++) begin
      check("t3 held gnt", 32'(gnt), 32'h02);
      check("t3 held timeout", 32'(timeout), 32'd0);
      step();
    end
    check("t3 drop gnt", 32'(gnt), 32'd0);
    check("t3 timeout pulse", 32'(timeout), 32'd1);
    step();
    check("t3 timeout single", 32'(timeout), 32'd0);
    check("t3 idle gnt", 32'(gnt), 32'd0);
    step();
    check("t3 regrant", 32'(gnt), 32'h02);

    // Release in the watchdog's final cycle: release wins, no timeout
    for (int i = 0; i < MAX_HOLD; i++) begin
      check("t4 held gnt", 32'(gnt), 32'h02);
      if (i == MAX_HOLD - 1) begin
        rel = 5'b00010;
      end
      step();
    end
    rel = '0;
    check("t4 drop gnt", 32'(gnt), 32'd0);
    check("t4 no timeout", 32'(timeout), 32'd0);
    req = '0;
    step();

    // Move ptr to 4, then wrap to 0; drop request; ignore foreign release
    req = 5'b01000;
    step();
    check("t5 grant 3", 32'(gnt_num), 32'd3);
    rel = 5'b01000;
    step();
    rel = '0;
    req = 5'b00011;
    step(); step();
    check("t5 wrap num", 32'(gnt_num), 32'd0);
    check("t5 wrap gnt", 32'(gnt), 32'h01);
    req = 5'b00010;
    step();
    check("t5 drop gnt", 32'(gnt), 32'd0);
    check("t5 drop timeout", 32'(timeout), 32'd0);
    step(); step();
    check("t5 next num", 32'(gnt_num), 32'd1);
    rel = 5'b01000;
    step();
    check("t5 foreign rel ignored", 32'(gnt), 32'h02);
    rel = '0;
    step();
    check("t5 still granted", 32'(gnt), 32'h02);
    req = '0;
    step(); step();

    // Reset mid-grant, then ptr back at 0
    req = 5'b00100;
    step(); step(); step();
    check("t6 granted before reset", 32'(gnt), 32'h04);
    rst_n = 1'b0;
    #1;
    check("t6 async gnt", 32'(gnt), 32'd0);
    check("t6 async val", 32'(gnt_val), 32'd0);
    check("t6 async timeout", 32'(timeout), 32'd0);
    check("t6 async num", 32'(gnt_num), 32'd0);
    req = 5'b10000;
    step();
    rst_n = 1'b1;
    step();
    check("t6 grant 4", 32'(gnt_num), 32'd4);
    check("t6 grant 4 gnt", 32'(gnt), 32'h10);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step();
    end
    check("t6 timeout pulse", 32'(timeout), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6 async timeout clear", 32'(timeout), 32'd0);
    req = '0;
    step();
    rst_n = 1'b1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
